// File: rtl/systolic_pkg.sv
// Shared defaults and helpers for the systolic-array edge blocks.
package systolic_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_DATA_FRAC  = 15;

  // Ceiling log2, at least 1 so single-entry fields still get a bit.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/adder.sv
// Pipelined saturating signed fixed-point adder; inputs are aligned up to OUTPUT_FRAC
// (input frac must not exceed output frac). Whole pipeline freezes while stall=1.
module adder #(
  parameter int unsigned INPUT_A_WIDTH = 16,
  parameter int unsigned INPUT_A_FRAC  = 15,
  parameter int unsigned INPUT_B_WIDTH = 16,
  parameter int unsigned INPUT_B_FRAC  = 15,
  parameter int unsigned OUTPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_FRAC   = 15,
  parameter int unsigned DELAY         = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     stall,
  input  logic [INPUT_A_WIDTH-1:0] a,
  input  logic [INPUT_B_WIDTH-1:0] b,
  output logic [OUTPUT_WIDTH-1:0]  out,
  output logic                     done
);

  localparam int unsigned SH_A = OUTPUT_FRAC - INPUT_A_FRAC;
  localparam int unsigned SH_B = OUTPUT_FRAC - INPUT_B_FRAC;
  localparam int unsigned WA   = INPUT_A_WIDTH + SH_A;
  localparam int unsigned WB   = INPUT_B_WIDTH + SH_B;
  localparam int unsigned WM   = (WA > WB) ? WA : WB;
  localparam int unsigned SW   = ((WM > OUTPUT_WIDTH) ? WM : OUTPUT_WIDTH) + 1;

  logic signed [SW-1:0]           a_ext, b_ext, sum;
  logic [SW-OUTPUT_WIDTH:0]       top_bits;
  logic [OUTPUT_WIDTH-1:0]        sat;
  logic [OUTPUT_WIDTH-1:0]        data_q [DELAY];
  logic [DELAY-1:0]               vld_q;

  assign a_ext    = SW'($signed(a)) <<< SH_A;
  assign b_ext    = SW'($signed(b)) <<< SH_B;
  assign sum      = a_ext + b_ext;
  assign top_bits = sum[SW-1:OUTPUT_WIDTH-1];

  // Result fits when every bit above the output sign bit matches it.
  always_comb begin
    sat = sum[OUTPUT_WIDTH-1:0];
    if (!((top_bits == '0) || (top_bits == '1)))
      sat = sum[SW-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DELAY; i++) data_q[i] <= '0;
    end else if (!stall) begin
      vld_q[0]  <= en;
      data_q[0] <= sat;
      for (int unsigned i = 1; i < DELAY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out  = data_q[DELAY-1];
  assign done = vld_q[DELAY-1];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one pipelined saturating adder among NUM_REQ requesters,
// with results tagged by issuer ID and output backpressure stalling the pipeline.
module adder_arbiter
  import systolic_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = systolic_pkg::DEF_DATA_WIDTH,
  parameter int unsigned DATA_FRAC  = systolic_pkg::DEF_DATA_FRAC,
  parameter int unsigned DELAY      = 1,
  localparam int unsigned ID_WIDTH  = systolic_pkg::clog2_f(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  localparam int unsigned CW = clog2_f(DELAY + 1);

  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q [DELAY];
  logic [ID_WIDTH-1:0]   id_d [DELAY];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   winner, cand;
  logic                  found, stall, issue, rsp_hs, add_done;
  logic [DATA_WIDTH-1:0] a_mux, b_mux, add_out;

  assign rsp_valid = add_done & ~reset;
  assign stall     = rsp_valid & ~rsp_ready;
  assign rsp_hs    = rsp_valid & rsp_ready;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign req_ready = (found && !stall && !reset) ? (NUM_REQ'(1) << winner) : '0;
  assign issue     = |(req_valid & req_ready);
  assign a_mux     = req_a[winner*DATA_WIDTH +: DATA_WIDTH];
  assign b_mux     = req_b[winner*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // ID shift register mirrors the adder pipeline so the tag lines up with done.
  always_comb begin
    id_d = id_q;
    if (!stall) begin
      id_d[0] = winner;
      for (int unsigned i = 1; i < DELAY; i++) id_d[i] = id_q[i-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({issue, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DELAY; i++) id_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      id_q  <= id_d;
    end
  end

  adder #(
    .INPUT_A_WIDTH (DATA_WIDTH),
    .INPUT_A_FRAC  (DATA_FRAC),
    .INPUT_B_WIDTH (DATA_WIDTH),
    .INPUT_B_FRAC  (DATA_FRAC),
    .OUTPUT_WIDTH  (DATA_WIDTH),
    .OUTPUT_FRAC   (DATA_FRAC),
    .DELAY         (DELAY)
  ) u_adder (
    .clk   (clk),
    .reset (reset),
    .en    (issue),
    .stall (stall),
    .a     (a_mux),
    .b     (b_mux),
    .out   (add_out),
    .done  (add_done)
  );

  assign rsp_id   = id_q[DELAY-1];
  assign rsp_data = add_out;
  assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench: one DELAY=1 and one DELAY=3 instance driven from a single linear sequence.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rr1, rv1, busy1;
  logic [3:0]  v1, rdy1;
  logic [63:0] a1, b1;
  logic [1:0]  rid1;
  logic [15:0] rd1;

  logic        rst3, rr3, rv3, busy3;
  logic [3:0]  v3, rdy3;
  logic [63:0] a3, b3;
  logic [1:0]  rid3;
  logic [15:0] rd3;

  int vectors = 0;
  int miscompares = 0;

  adder_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .DATA_FRAC(15), .DELAY(1)) dut1 (
    .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1), .req_a(a1), .req_b(b1),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_id(rid1), .rsp_data(rd1), .busy(busy1)
  );

  adder_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .DATA_FRAC(15), .DELAY(3)) dut3 (
    .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3), .req_a(a3), .req_b(b3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(rid3), .rsp_data(rd3), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic rsp3(input string tag, input logic v, input logic [1:0] id, input logic [15:0] d);
    chk({tag, "_valid"}, 32'(rv3), 32'(v));
    chk({tag, "_id"},    32'(rid3), 32'(id));
    chk({tag, "_data"},  32'(rd3), 32'(d));
  endtask

  initial begin
    rst1 = 1'b1; rr1 = 1'b1; v1 = 4'hF; a1 = '0; b1 = '0;
    rst3 = 1'b1; rr3 = 1'b1; v3 = 4'hF; a3 = '0; b3 = '0;
    tick(); tick();
    chk("rst_ready1", 32'(rdy1), 32'h0);
    chk("rst_valid1", 32'(rv1), 32'h0);
    chk("rst_busy1",  32'(busy1), 32'h0);
    chk("rst_id1",    32'(rid1), 32'h0);
    chk("rst_ready3", 32'(rdy3), 32'h0);
    chk("rst_busy3",  32'(busy3), 32'h0);

    // 1: single op on DELAY=1
    rst1 = 1'b0; rst3 = 1'b0; v3 = 4'h0;
    v1 = 4'b0001; a1[15:0] = 16'h4000; b1[15:0] = 16'h2000;
    #1 chk("t1_grant", 32'(rdy1), 32'h1);
    chk("t1_busy0", 32'(busy1), 32'h0);
    tick(); v1 = 4'h0;
    chk("t1_valid", 32'(rv1), 32'h1);
    chk("t1_data",  32'(rd1), 32'h6000);
    chk("t1_id",    32'(rid1), 32'h0);
    chk("t1_busy",  32'(busy1), 32'h1);
    tick();
    chk("t1_valid_off", 32'(rv1), 32'h0);
    chk("t1_busy_off",  32'(busy1), 32'h0);

    // 2: saturation both directions (ptr=1, so req0 wins after a wrap)
    v1 = 4'b0001; a1[15:0] = 16'h7000; b1[15:0] = 16'h2000;
    #1 chk("t2_grant_a", 32'(rdy1), 32'h1);
    tick(); a1[15:0] = 16'h9000; b1[15:0] = 16'hA000;
    chk("t2_pos_data", 32'(rd1), 32'h7FFF);
    chk("t2_pos_id",   32'(rid1), 32'h0);
    #1 chk("t2_grant_b", 32'(rdy1), 32'h1);
    tick(); v1 = 4'h0;
    chk("t2_neg_valid", 32'(rv1), 32'h1);
    chk("t2_neg_data",  32'(rd1), 32'h8000);
    tick();

    // 3: fairness with all four valid, starting from ptr=0
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1[i*16 +: 16] = 16'(16'h0100 * (i + 1));
      b1[i*16 +: 16] = 16'h0010;
    end
    v1 = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("t3_grant%0d", k), 32'(rdy1), 32'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("t3_id%0d", k), 32'(rid1), 32'((k - 1) % 4));
        chk($sformatf("t3_data%0d", k), 32'(rd1), 32'(16'h0100 * ((k - 1) % 4 + 1) + 16'h0010));
      end
      tick();
    end
    v1 = 4'h0;
    chk("t3_last_id",   32'(rid1), 32'h1);
    chk("t3_last_data", 32'(rd1), 32'h0210);
    tick();
    chk("t3_busy_off", 32'(busy1), 32'h0);

    // 4: backpressure on DELAY=3
    a3 = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    b3 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    rr3 = 1'b0; v3 = 4'b0111;
    #1 chk("t4_grant0", 32'(rdy3), 32'h1);
    tick(); v3 = 4'b0110;
    #1 chk("t4_grant1", 32'(rdy3), 32'h2);
    chk("t4_c1_valid", 32'(rv3), 32'h0);
    tick(); v3 = 4'b0100;
    #1 chk("t4_grant2", 32'(rdy3), 32'h4);
    tick(); v3 = 4'b1000;
    for (int s = 0; s < 4; s++) begin
      #1 chk($sformatf("t4_stall_ready%0d", s), 32'(rdy3), 32'h0);
      rsp3($sformatf("t4_hold%0d", s), 1'b1, 2'd0, 16'h1001);
      chk($sformatf("t4_stall_busy%0d", s), 32'(busy3), 32'h1);
      tick();
    end
    rr3 = 1'b1;
    #1 chk("t4_release_grant", 32'(rdy3), 32'h8);
    rsp3("t4_r0", 1'b1, 2'd0, 16'h1001);
    tick(); v3 = 4'h0;
    rsp3("t4_r1", 1'b1, 2'd1, 16'h2002);
    tick();
    rsp3("t4_r2", 1'b1, 2'd2, 16'h3003);
    tick();
    rsp3("t4_r3", 1'b1, 2'd3, 16'h4004);
    chk("t4_busy_last", 32'(busy3), 32'h1);
    tick();
    chk("t4_valid_off", 32'(rv3), 32'h0);
    chk("t4_busy_off",  32'(busy3), 32'h0);

    // 5: reset with two ops in flight; ptr would otherwise be 3
    v3 = 4'b0110;
    #1 chk("t5_grant1", 32'(rdy3), 32'h2);
    tick(); v3 = 4'b0100;
    #1 chk("t5_grant2", 32'(rdy3), 32'h4);
    tick(); v3 = 4'h0;
    chk("t5_busy_inflight", 32'(busy3), 32'h1);
    rst3 = 1'b1; v3 = 4'b1010; a3[31:16] = 16'h0100; b3[31:16] = 16'h0200;
    #1 chk("t5_rst_ready", 32'(rdy3), 32'h0);
    tick();
    chk("t5_rst_valid", 32'(rv3), 32'h0);
    chk("t5_rst_busy",  32'(busy3), 32'h0);
    tick(); rst3 = 1'b0;
    #1 chk("t5_restart_grant", 32'(rdy3), 32'h2);
    tick(); v3 = 4'h0;
    chk("t5_no_stale_a", 32'(rv3), 32'h0);
    tick();
    chk("t5_no_stale_b", 32'(rv3), 32'h0);
    tick();
    rsp3("t5_new", 1'b1, 2'd1, 16'h0300);
    tick();
    chk("t5_busy_off", 32'(busy3), 32'h0);

    // 6: sparse requests, pointer wraps from 3 to requester 1
    v3 = 4'b0100; a3[47:32] = 16'h0010; b3[47:32] = 16'h0020;
    #1 chk("t6_grant2", 32'(rdy3), 32'h4);
    tick(); v3 = 4'b0010; a3[31:16] = 16'h0005; b3[31:16] = 16'h0006;
    #1 chk("t6_grant1", 32'(rdy3), 32'h2);
    tick(); v3 = 4'h0;
    chk("t6_c2_valid", 32'(rv3), 32'h0);
    chk("t6_c2_busy",  32'(busy3), 32'h1);
    tick();
    rsp3("t6_r2", 1'b1, 2'd2, 16'h0030);
    tick();
    rsp3("t6_r1", 1'b1, 2'd1, 16'h000B);
    chk("t6_busy_last", 32'(busy3), 32'h1);
    tick();
    chk("t6_busy_off", 32'(busy3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
